// File: rtl/mc_main_control.sv
// Multicycle main control FSM for the MIPS-lite datapath.
// Sequences fetch/decode/execute/memory/writeback, drives the ALU-control
// opcode bits and all datapath enables, and counts retired instructions.
//
// Handshake: mem_ready is a completion strobe for the access the FSM is
// currently presenting (FETCH, MEMRD, MEMWR). While it is 0 the FSM holds its
// state and its decoded outputs. The exception is the FETCH pcwrite/irwrite
// pair, which fires only in the cycle where mem_ready is 1.
module mc_main_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             alusrca,
  output logic             regwrite,
  output logic             regdst,
  output logic             zeroext,
  output logic             aluop1,
  output logic             aluop0,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsource,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    RWB    = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    ORIEX  = 4'd11,
    ORIWB  = 4'd12
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_ORI = 6'b001101;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire_ev;

  assign state   = state_q;
  assign retired = retired_q;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Retired counter advances on the edge that lands back in FETCH after a
  // completed instruction; wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         retired_q <= '0;
    else if (retire_ev) retired_q <= retired_q + CNT_W'(1);
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    retire_ev   = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    alusrca     = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    zeroext     = 1'b0;
    aluop1      = 1'b0;
    aluop0      = 1'b0;
    alusrcb     = 2'b00;
    pcsource    = 2'b00;
    illegal_op  = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ORI:       state_d = ORIEX;
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        // Only lw/sw reach MEMADR, so anything other than lw is a store.
        state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        regwrite  = 1'b1;
        memtoreg  = 1'b1;
        state_d   = FETCH;
        retire_ev = 1'b1;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d   = FETCH;
          retire_ev = 1'b1;
        end
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop1  = 1'b1;
        state_d = RWB;
      end
      RWB: begin
        regwrite  = 1'b1;
        regdst    = 1'b1;
        state_d   = FETCH;
        retire_ev = 1'b1;
      end
      BRANCH: begin
        alusrca     = 1'b1;
        aluop0      = 1'b1;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        state_d     = FETCH;
        retire_ev   = 1'b1;
      end
      JUMP: begin
        pcwrite   = 1'b1;
        pcsource  = 2'b10;
        state_d   = FETCH;
        retire_ev = 1'b1;
      end
      ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        zeroext = 1'b1;
        aluop1  = 1'b1;
        state_d = ORIWB;
      end
      ORIWB: begin
        regwrite  = 1'b1;
        state_d   = FETCH;
        retire_ev = 1'b1;
      end
      // Unused codes 13-15 recover to IDLE with every output quiet.
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: walks each opcode class through its
// state sequence and checks state, packed controls, illegal_op and retired.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg;
  logic       alusrca, regwrite, regdst, zeroext, aluop1, aluop0, illegal_op;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] state;
  logic [15:0] retired;

  // Narrow-counter instance sharing the same inputs, used to see the wrap.
  logic       s_pcwrite, s_pcwritecond, s_iord, s_memread, s_memwrite, s_irwrite;
  logic       s_memtoreg, s_alusrca, s_regwrite, s_regdst, s_zeroext;
  logic       s_aluop1, s_aluop0, s_illegal_op;
  logic [1:0] s_alusrcb, s_pcsource;
  logic [3:0] s_state;
  logic [1:0] s_retired;

  int total = 0;
  int bad   = 0;

  mc_main_control #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .alusrca(alusrca), .regwrite(regwrite),
    .regdst(regdst), .zeroext(zeroext), .aluop1(aluop1), .aluop0(aluop0),
    .alusrcb(alusrcb), .pcsource(pcsource), .illegal_op(illegal_op),
    .state(state), .retired(retired)
  );

  mc_main_control #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(s_pcwrite), .pcwritecond(s_pcwritecond), .iord(s_iord),
    .memread(s_memread), .memwrite(s_memwrite), .irwrite(s_irwrite),
    .memtoreg(s_memtoreg), .alusrca(s_alusrca), .regwrite(s_regwrite),
    .regdst(s_regdst), .zeroext(s_zeroext), .aluop1(s_aluop1),
    .aluop0(s_aluop0), .alusrcb(s_alusrcb), .pcsource(s_pcsource),
    .illegal_op(s_illegal_op), .state(s_state), .retired(s_retired)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // Packed control word, order:
  // pcw pcwc iord mrd mwr irw m2r asa rw rd zx aluop[1:0] alusrcb[1:0] pcsource[1:0]
  function automatic logic [16:0] mk(input logic pcw, pcwc, io, mrd, mwr, irw,
                                     m2r, asa, rw, rd, zx,
                                     input logic [1:0] aop, asb, ps);
    return {pcw, pcwc, io, mrd, mwr, irw, m2r, asa, rw, rd, zx, aop, asb, ps};
  endfunction

  logic [16:0] ctl;
  assign ctl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                alusrca, regwrite, regdst, zeroext, aluop1, aluop0, alusrcb, pcsource};

  localparam logic [3:0] S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3,
    S_MEMRD = 4, S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7, S_RWB = 8, S_BRANCH = 9,
    S_JUMP = 10, S_ORIEX = 11, S_ORIWB = 12;

  logic [16:0] e_zero, e_fetch, e_fstall, e_dec, e_madr, e_mrd, e_mwb, e_mwr;
  logic [16:0] e_exec, e_rwb, e_br, e_jmp, e_oriex, e_oriwb;

  initial begin
    e_zero   = '0;
    e_fetch  = mk(1,0,0,1,0,1,0,0,0,0,0,2'b00,2'b01,2'b00);
    e_fstall = mk(0,0,0,1,0,0,0,0,0,0,0,2'b00,2'b01,2'b00);
    e_dec    = mk(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b11,2'b00);
    e_madr   = mk(0,0,0,0,0,0,0,1,0,0,0,2'b00,2'b10,2'b00);
    e_mrd    = mk(0,0,1,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00);
    e_mwb    = mk(0,0,0,0,0,0,1,0,1,0,0,2'b00,2'b00,2'b00);
    e_mwr    = mk(0,0,1,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00);
    e_exec   = mk(0,0,0,0,0,0,0,1,0,0,0,2'b10,2'b00,2'b00);
    e_rwb    = mk(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00);
    e_br     = mk(0,1,0,0,0,0,0,1,0,0,0,2'b01,2'b00,2'b01);
    e_jmp    = mk(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10);
    e_oriex  = mk(0,0,0,0,0,0,0,1,0,0,1,2'b10,2'b10,2'b00);
    e_oriwb  = mk(0,0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00);
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: let inputs settle, check state/controls/illegal, advance.
  task automatic cyc(input string tag, input logic [3:0] s, input logic [16:0] c,
                     input logic ill);
    #1;
    check({tag, ".state"}, 32'(state), 32'(s));
    check({tag, ".ctl"}, 32'(ctl), 32'(c));
    check({tag, ".illegal"}, 32'(illegal_op), 32'(ill));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    #3;
    check("rst.state", 32'(state), 32'(S_IDLE));
    check("rst.ctl", 32'(ctl), 32'(e_zero));
    check("rst.retired", 32'(retired), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle.state", 32'(state), 32'(S_IDLE));
    @(posedge clk);
    #1;

    // lw: 0,1,2,3,4,5,1
    opcode = 6'b100011;
    cyc("lw.fetch", S_FETCH, e_fetch, 0);
    cyc("lw.decode", S_DECODE, e_dec, 0);
    cyc("lw.memadr", S_MEMADR, e_madr, 0);
    cyc("lw.memrd", S_MEMRD, e_mrd, 0);
    check("lw.retired_before", 32'(retired), 0);
    cyc("lw.memwb", S_MEMWB, e_mwb, 0);
    check("lw.retired", 32'(retired), 1);

    // R-type; opcode changed during EXEC must be ignored
    opcode = 6'b000000;
    cyc("r.fetch", S_FETCH, e_fetch, 0);
    cyc("r.decode", S_DECODE, e_dec, 0);
    opcode = 6'b100011;
    cyc("r.exec", S_EXEC, e_exec, 0);
    cyc("r.rwb", S_RWB, e_rwb, 0);
    check("r.retired", 32'(retired), 2);

    // ori
    opcode = 6'b001101;
    cyc("ori.fetch", S_FETCH, e_fetch, 0);
    cyc("ori.decode", S_DECODE, e_dec, 0);
    cyc("ori.oriex", S_ORIEX, e_oriex, 0);
    cyc("ori.oriwb", S_ORIWB, e_oriwb, 0);
    check("ori.retired", 32'(retired), 3);

    // beq; fourth retirement wraps the 2-bit counter
    opcode = 6'b000100;
    cyc("beq.fetch", S_FETCH, e_fetch, 0);
    cyc("beq.decode", S_DECODE, e_dec, 0);
    cyc("beq.branch", S_BRANCH, e_br, 0);
    check("beq.retired", 32'(retired), 4);
    check("wrap.small_retired", 32'(s_retired), 0);

    // FETCH stalled 3 cycles, then sw with 2 stall cycles in MEMWR
    opcode    = 6'b101011;
    mem_ready = 1'b0;
    cyc("sw.fetch_stall0", S_FETCH, e_fstall, 0);
    cyc("sw.fetch_stall1", S_FETCH, e_fstall, 0);
    cyc("sw.fetch_stall2", S_FETCH, e_fstall, 0);
    mem_ready = 1'b1;
    cyc("sw.fetch_ready", S_FETCH, e_fetch, 0);
    cyc("sw.decode", S_DECODE, e_dec, 0);
    cyc("sw.memadr", S_MEMADR, e_madr, 0);
    mem_ready = 1'b0;
    cyc("sw.memwr_stall0", S_MEMWR, e_mwr, 0);
    check("sw.retired_stall", 32'(retired), 4);
    cyc("sw.memwr_stall1", S_MEMWR, e_mwr, 0);
    mem_ready = 1'b1;
    cyc("sw.memwr_ready", S_MEMWR, e_mwr, 0);
    check("sw.retired", 32'(retired), 5);

    // illegal opcode: 2 cycles, no retirement
    opcode = 6'b111111;
    cyc("ill.fetch", S_FETCH, e_fetch, 0);
    cyc("ill.decode", S_DECODE, e_dec, 1);
    check("ill.retired", 32'(retired), 5);

    // j
    opcode = 6'b000010;
    cyc("j.fetch", S_FETCH, e_fetch, 0);
    cyc("j.decode", S_DECODE, e_dec, 0);
    cyc("j.jump", S_JUMP, e_jmp, 0);
    check("j.retired", 32'(retired), 6);
    check("j.small_retired", 32'(s_retired), 2);

    // lw aborted by asynchronous reset during MEMRD
    opcode = 6'b100011;
    cyc("abort.fetch", S_FETCH, e_fetch, 0);
    cyc("abort.decode", S_DECODE, e_dec, 0);
    cyc("abort.memadr", S_MEMADR, e_madr, 0);
    #1;
    check("abort.in_memrd", 32'(state), 32'(S_MEMRD));
    rst_n = 1'b0;
    #1;
    check("abort.state", 32'(state), 32'(S_IDLE));
    check("abort.ctl", 32'(ctl), 32'(e_zero));
    check("abort.retired", 32'(retired), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort.idle_after_release", 32'(state), 32'(S_IDLE));
    @(posedge clk);
    #1;
    cyc("abort.refetch", S_FETCH, e_fetch, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
